// File: rtl/vga_timing_36mhz.sv
// vga_timing_36mhz
// Raster timing generator for VESA 800x600@56Hz, clocked by the 36 MHz pixel clock.
// Every output is a register loaded from the next-state counter values, so all
// outputs describe the same (h_cnt, v_cnt) position in any given cycle.
// Ports:
//   clk_36MHz    - pixel clock
//   reset_n      - synchronous active-low reset
//   hsync/vsync  - sync pulses, level SYNC_POL while asserted
//   video_active - inside the visible 800x600 area
//   pix_x/pix_y  - current h_cnt / v_cnt
//   line_start   - pulse at h_cnt==0
//   frame_start  - pulse at h_cnt==0, v_cnt==0
//   fetch_en     - pixel (fetch_x, fetch_y) becomes visible PREFETCH cycles later
//   fetch_x/y    - look-ahead coordinate, 0 when fetch_en is low
module vga_timing_36mhz #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 72,
    parameter int H_BP     = 128,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 22,
    parameter int SYNC_POL = 1,
    parameter int PREFETCH = 2
) (
    input  logic       clk_36MHz,
    input  logic       reset_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_active,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_start,
    output logic       frame_start,
    output logic       fetch_en,
    output logic [9:0] fetch_x,
    output logic [9:0] fetch_y
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = (H_TOTAL > 1024) ? 11 : 10;
    localparam int VW = (V_TOTAL > 1024) ? 11 : 10;

    // Constants are one bit wider than the counters so that range ends equal
    // to the total (e.g. zero back porch) never overflow.
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW:0]   H_TOT_W  = (HW+1)'(H_TOTAL);
    localparam logic [HW:0]   H_ACT_W  = (HW+1)'(H_ACTIVE);
    localparam logic [VW:0]   V_ACT_W  = (VW+1)'(V_ACTIVE);
    localparam logic [HW:0]   HS_BEG   = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0]   HS_END   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0]   VS_BEG   = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0]   VS_END   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW:0]   PF_W     = (HW+1)'(PREFETCH);
    localparam logic          SP       = (SYNC_POL != 0);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    logic          w_h_wrap;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic [HW:0]   w_fsum;
    logic          w_fwrap;
    logic [HW-1:0] w_fcol;
    logic [VW-1:0] w_frow;
    logic          w_fen;
    logic          w_hs;
    logic          w_vs;
    logic          w_va;

    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + 1'b1;
    assign w_v_nxt  = w_h_wrap ? ((r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1) : r_v_cnt;

    // Look-ahead target: column wraps modulo H_TOTAL, and a wrap pushes the
    // row forward one line (modulo V_TOTAL), so the last line fetches row 0.
    assign w_fsum  = {1'b0, w_h_nxt} + PF_W;
    assign w_fwrap = (w_fsum >= H_TOT_W);
    assign w_fcol  = w_fwrap ? HW'(w_fsum - H_TOT_W) : HW'(w_fsum);
    assign w_frow  = w_fwrap ? ((w_v_nxt == V_LAST) ? '0 : w_v_nxt + 1'b1) : w_v_nxt;
    assign w_fen   = ({1'b0, w_fcol} < H_ACT_W) && ({1'b0, w_frow} < V_ACT_W);

    assign w_hs = ({1'b0, w_h_nxt} >= HS_BEG) && ({1'b0, w_h_nxt} < HS_END);
    assign w_vs = ({1'b0, w_v_nxt} >= VS_BEG) && ({1'b0, w_v_nxt} < VS_END);
    assign w_va = ({1'b0, w_h_nxt} < H_ACT_W) && ({1'b0, w_v_nxt} < V_ACT_W);

    always_ff @(posedge clk_36MHz) begin
        if (!reset_n) begin
            // Parked on the last position so the first released edge lands on (0,0).
            r_h_cnt      <= H_LAST;
            r_v_cnt      <= V_LAST;
            hsync        <= ~SP;
            vsync        <= ~SP;
            video_active <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            fetch_en     <= 1'b0;
            fetch_x      <= '0;
            fetch_y      <= '0;
        end else begin
            r_h_cnt      <= w_h_nxt;
            r_v_cnt      <= w_v_nxt;
            hsync        <= w_hs ? SP : ~SP;
            vsync        <= w_vs ? SP : ~SP;
            video_active <= w_va;
            pix_x        <= 10'(w_h_nxt);
            pix_y        <= 10'(w_v_nxt);
            line_start   <= (w_h_nxt == '0);
            frame_start  <= (w_h_nxt == '0) && (w_v_nxt == '0);
            fetch_en     <= w_fen;
            fetch_x      <= w_fen ? 10'(w_fcol) : '0;
            fetch_y      <= w_fen ? 10'(w_frow) : '0;
        end
    end
endmodule

// File: tb/tb_vga_timing_36mhz.sv
// Bench: a default-parameter instance for line-level timing, plus a shrunken
// instance (64x26 total, SYNC_POL=0) so whole-frame behaviour fits in a short run.
module tb_vga_timing_36mhz;
    typedef struct packed {
        logic hs, vs, va, ls, fs, fe;
        logic [9:0] x, y, fx, fy;
    } obs_t;

    typedef struct {
        int   cyc;
        bit   sel;   // 0: default instance, 1: small instance
        obs_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic d_hs, d_vs, d_va, d_ls, d_fs, d_fe;
    logic [9:0] d_x, d_y, d_fx, d_fy;
    logic s_hs, s_vs, s_va, s_ls, s_fs, s_fe;
    logic [9:0] s_x, s_y, s_fx, s_fy;
    obs_t d_o, s_o;
    assign d_o = {d_hs, d_vs, d_va, d_ls, d_fs, d_fe, d_x, d_y, d_fx, d_fy};
    assign s_o = {s_hs, s_vs, s_va, s_ls, s_fs, s_fe, s_x, s_y, s_fx, s_fy};

    vga_timing_36mhz dut (
        .clk_36MHz(clk), .reset_n(reset_n),
        .hsync(d_hs), .vsync(d_vs), .video_active(d_va),
        .pix_x(d_x), .pix_y(d_y), .line_start(d_ls), .frame_start(d_fs),
        .fetch_en(d_fe), .fetch_x(d_fx), .fetch_y(d_fy)
    );

    vga_timing_36mhz #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(14),
        .V_ACTIVE(20), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(0), .PREFETCH(2)
    ) dut_s (
        .clk_36MHz(clk), .reset_n(reset_n),
        .hsync(s_hs), .vsync(s_vs), .video_active(s_va),
        .pix_x(s_x), .pix_y(s_y), .line_start(s_ls), .frame_start(s_fs),
        .fetch_en(s_fe), .fetch_x(s_fx), .fetch_y(s_fy)
    );

    int nchk = 0;
    int nerr = 0;

    // Cycle index since reset release: 0 is the first edge with reset_n high.
    int cyc;
    always @(posedge clk) begin
        if (!reset_n) cyc <= -1;
        else          cyc <= cyc + 1;
    end

    // Counters for the multi-cycle measurements.
    bit mon_en = 1'b1;
    int d_va_n = 0, d_hs_n = 0, d_hs_first = -1;
    int s_va_n = 0, s_vs_n = 0, s_vs_first = -1, s_fs_n = 0, s_fs_prev = -1, s_fs_per = -1;
    always @(negedge clk) begin
        if (mon_en && reset_n && cyc >= 0) begin
            if (cyc < 1024) begin
                d_va_n <= d_va_n + int'(d_va);
                d_hs_n <= d_hs_n + int'(d_hs);
                if (d_hs && d_hs_first < 0) d_hs_first <= cyc;
            end
            if (cyc < 3328) begin
                s_va_n <= s_va_n + int'(s_va);
                if (!s_vs) begin
                    s_vs_n <= s_vs_n + 1;
                    if (s_vs_first < 0) s_vs_first <= cyc;
                end
                if (s_fs) begin
                    s_fs_n <= s_fs_n + 1;
                    if (s_fs_prev >= 0) s_fs_per <= cyc - s_fs_prev;
                    s_fs_prev <= cyc;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int c, input bit s,
                                input bit hs, input bit vs, input bit va,
                                input bit ls, input bit fs, input bit fe,
                                input int x, input int y, input int fx, input int fy);
        vec_t v;
        v.cyc = c;
        v.sel = s;
        v.e   = {hs, vs, va, ls, fs, fe, 10'(x), 10'(y), 10'(fx), 10'(fy)};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    vec_t tbl[$];
    obs_t idle_d, idle_s, start_d, start_s;

    initial begin
        idle_d  = {1'b0, 1'b0, 4'b0, 40'b0};
        idle_s  = {1'b1, 1'b1, 4'b0, 40'b0};
        start_d = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 10'd2, 10'd0};
        start_s = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 10'd2, 10'd0};

        //                    cyc  sel hs vs va ls fs fe     x    y   fx  fy
        tbl.push_back(mk(   0, 0,  0, 0, 1, 1, 1, 1,    0,   0,   2,  0));
        tbl.push_back(mk(   0, 1,  1, 1, 1, 1, 1, 1,    0,   0,   2,  0));
        tbl.push_back(mk(   1, 0,  0, 0, 1, 0, 0, 1,    1,   0,   3,  0));
        tbl.push_back(mk(  43, 1,  1, 1, 0, 0, 0, 0,   43,   0,   0,  0));
        tbl.push_back(mk(  44, 1,  0, 1, 0, 0, 0, 0,   44,   0,   0,  0));
        tbl.push_back(mk(  49, 1,  0, 1, 0, 0, 0, 0,   49,   0,   0,  0));
        tbl.push_back(mk(  50, 1,  1, 1, 0, 0, 0, 0,   50,   0,   0,  0));
        tbl.push_back(mk( 797, 0,  0, 0, 1, 0, 0, 1,  797,   0, 799,  0));
        tbl.push_back(mk( 798, 0,  0, 0, 1, 0, 0, 0,  798,   0,   0,  0));
        tbl.push_back(mk( 799, 0,  0, 0, 1, 0, 0, 0,  799,   0,   0,  0));
        tbl.push_back(mk( 800, 0,  0, 0, 0, 0, 0, 0,  800,   0,   0,  0));
        tbl.push_back(mk( 823, 0,  0, 0, 0, 0, 0, 0,  823,   0,   0,  0));
        tbl.push_back(mk( 824, 0,  1, 0, 0, 0, 0, 0,  824,   0,   0,  0));
        tbl.push_back(mk( 895, 0,  1, 0, 0, 0, 0, 0,  895,   0,   0,  0));
        tbl.push_back(mk( 896, 0,  0, 0, 0, 0, 0, 0,  896,   0,   0,  0));
        tbl.push_back(mk(1021, 0,  0, 0, 0, 0, 0, 0, 1021,   0,   0,  0));
        tbl.push_back(mk(1022, 0,  0, 0, 0, 0, 0, 1, 1022,   0,   0,  1));
        tbl.push_back(mk(1023, 0,  0, 0, 0, 0, 0, 1, 1023,   0,   1,  1));
        tbl.push_back(mk(1024, 0,  0, 0, 1, 1, 0, 1,    0,   1,   2,  1));
        tbl.push_back(mk(1278, 1,  1, 1, 0, 0, 0, 0,   62,  19,   0,  0));
        tbl.push_back(mk(1279, 1,  1, 1, 0, 0, 0, 0,   63,  19,   0,  0));
        tbl.push_back(mk(1343, 1,  1, 1, 0, 0, 0, 0,   63,  20,   0,  0));
        tbl.push_back(mk(1344, 1,  1, 0, 0, 1, 0, 0,    0,  21,   0,  0));
        tbl.push_back(mk(1471, 1,  1, 0, 0, 0, 0, 0,   63,  22,   0,  0));
        tbl.push_back(mk(1472, 1,  1, 1, 0, 1, 0, 0,    0,  23,   0,  0));
        tbl.push_back(mk(1662, 1,  1, 1, 0, 0, 0, 1,   62,  25,   0,  0));
        tbl.push_back(mk(1663, 1,  1, 1, 0, 0, 0, 1,   63,  25,   1,  0));
        tbl.push_back(mk(1664, 1,  1, 1, 1, 1, 1, 1,    0,   0,   2,  0));

        // Reset held for 5 cycles; outputs must sit at idle levels.
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_idle_default", 64'(d_o), 64'(idle_d));
        chk("reset_idle_small",   64'(s_o), 64'(idle_s));
        reset_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            while (cyc < tbl[i].cyc) @(negedge clk);
            chk($sformatf("vec%0d_%s_cyc%0d", i, tbl[i].sel ? "small" : "dflt", tbl[i].cyc),
                64'(tbl[i].sel ? s_o : d_o), 64'(tbl[i].e));
        end

        while (cyc < 3330) @(negedge clk);
        chk("line_video_active_cycles", 64'(d_va_n), 64'd800);
        chk("line_hsync_cycles",        64'(d_hs_n), 64'd72);
        chk("line_hsync_first",         64'(d_hs_first), 64'd824);
        chk("frame_video_active_cycles", 64'(s_va_n), 64'd1600);
        chk("frame_vsync_cycles",       64'(s_vs_n), 64'd256);
        chk("frame_vsync_first",        64'(s_vs_first), 64'd1344);
        chk("frame_start_count",        64'(s_fs_n), 64'd2);
        chk("frame_start_period",       64'(s_fs_per), 64'd1664);

        // Mid-frame reset pulse: small instance at line 10, column 20.
        mon_en = 1'b0;
        while (cyc < 3988) @(negedge clk);
        chk("midframe_pos_small", 64'({s_x, s_y}), 64'({10'd20, 10'd10}));
        chk("midframe_pos_dflt",  64'({d_x, d_y}), 64'({10'd916, 10'd3}));
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_idle_default", 64'(d_o), 64'(idle_d));
        chk("midreset_idle_small",   64'(s_o), 64'(idle_s));
        reset_n = 1'b1;
        @(negedge clk);
        chk("restart_default", 64'(d_o), 64'(start_d));
        chk("restart_small",   64'(s_o), 64'(start_s));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
